// File: rtl/wired_cdb_arbiter.sv
// Two-lane CDB arbiter: four producers (ALU0, ALU1, LSU, MDU) share the bank-split CDB,
// with fixed priority per lane plus a saturating starvation promotion.
package pipeline_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [4:0]  excp;
        logic        need_jump;
        logic [31:0] target_addr;
        logic        uncached;
        logic [31:0] wdata;
        logic [5:0]  wid;
    } pipeline_cdb_t;
endpackage

module wired_cdb_arbiter
    import pipeline_cdb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned BANK_BIT     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  pipeline_cdb_t [3:0] src_cdb_i,
    output logic          [3:0] src_ready_o,
    output pipeline_cdb_t [1:0] cdb_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt [4];
    logic [3:0] promoted;
    logic [3:0] eligible   [2];
    logic [3:0] candidates [2];
    logic [1:0] win_idx    [2];
    logic [1:0] lane_hit;
    logic [3:0] grant;

    function automatic logic [1:0] lowest(input logic [3:0] req);
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) lowest = 2'(i);
        end
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        grant    = '0;
        lane_hit = '0;
        for (int s = 0; s < 4; s++) begin
            promoted[s] = (starve_cnt[s] == LIMIT);
        end
        for (int l = 0; l < 2; l++) begin
            win_idx[l] = 2'd0;
            for (int s = 0; s < 4; s++) begin
                eligible[l][s] = src_cdb_i[s].valid && (src_cdb_i[s].wid[BANK_BIT] == 1'(l));
            end
            // A promoted requester on this lane preempts the plain priority order.
            candidates[l] = (|(eligible[l] & promoted)) ? (eligible[l] & promoted) : eligible[l];
            lane_hit[l]   = |candidates[l];
            win_idx[l]    = lowest(candidates[l]);
            if (lane_hit[l]) grant[win_idx[l]] = 1'b1;
        end
    end

    assign src_ready_o = grant & {4{!flush_i && rst_n}};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) starve_cnt[s] <= '0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (flush_i || !src_cdb_i[s].valid || grant[s]) begin
                    starve_cnt[s] <= '0;
                end else if (starve_cnt[s] != LIMIT) begin
                    starve_cnt[s] <= starve_cnt[s] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_o <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (flush_i || !lane_hit[l]) begin
                    cdb_o[l] <= '0;
                end else begin
                    cdb_o[l] <= src_cdb_i[win_idx[l]];
                end
            end
        end
    end

endmodule

// File: doc/wired_cdb_arbiter.md
# wired_cdb_arbiter

Shares the two common data bus (CDB) lanes among the four result producers: ALU0, ALU1, LSU and MDU. Each cycle it grants at most one producer per lane, and a producer may only use the lane matching its ROB write bank. Arbitration is fixed priority ALU0 > ALU1 > LSU > MDU, with an anti-starvation promotion. It sits between the execution units' output FIFOs (for example the LSU commit FIFO) and the ROB / issue-queue CDB snoop ports, and drives registered CDB lanes.

## Interface
Parameters:
- STARVE_LIMIT, default 8: cycles a valid, ungranted source waits before it is promoted (range 1..255).
- BANK_BIT, default 0: bit of `wid` that selects the ROB bank, and therefore the CDB lane.

Ports (clock and reset first):
- clk  input  1  single clock; all state on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush_i  input  1  backend flush; drops the outputs and clears arbitration state.
- src_cdb_i  input  [3:0] pipeline_cdb_t  candidate results: index 0 ALU0, 1 ALU1, 2 LSU, 3 MDU; `.valid` is the request.
- src_ready_o  output  [3:0]  grant/accept per source; a transfer happens when valid and ready are both high.
- cdb_o  output  [1:0] pipeline_cdb_t  registered CDB lanes; lane l carries only `wid[BANK_BIT]==l`.

## Operation
- Lane eligibility: source s requests lane l when `src_cdb_i[s].valid && src_cdb_i[s].wid[BANK_BIT]==l`. Each source requests exactly one lane.
- Starve counter per source, 8 bits, saturating at STARVE_LIMIT:
  - cleared when the source is invalid, granted, or flush_i is high;
  - otherwise incremented by 1.
- Promoted: counter == STARVE_LIMIT.
- Per-lane winner:
  - if any eligible source is promoted, the lowest-index promoted eligible source wins;
  - otherwise the lowest-index eligible source wins.
- The two lanes are independent, so at most 2 grants per cycle, one per lane.
- src_ready_o[s] = grant[s] && !flush_i. It is combinational from src_cdb_i. Sources must not derive valid from ready.
- Output register per lane: next cdb_o[l] = winner payload with `.valid=1`, or all fields 0 with `.valid=0` if there is no winner. Payload fields pass unmodified: excp, need_jump, target_addr, uncached, wdata, wid.
- Flush: while flush_i is high, src_ready_o = 0, the next cdb_o valids are 0, and all counters clear. Held payload fields may keep stale data but valid must be 0.
- Reset (asynchronous, any cycle, including mid-grant): cdb_o valids 0, payloads 0, counters 0. src_ready_o is combinational and follows inputs once rst_n deasserts. While rst_n is low, src_ready_o = 0.

## Timing
- Latency: a result accepted in cycle N appears on cdb_o in cycle N+1, for exactly one cycle.
- Throughput: 2 results/cycle when the winners map to different banks.
- Same-bank losers hold valid and payload stable. They retry each cycle, with no reordering within a source.
- Starvation bound: a continuously valid source is granted within STARVE_LIMIT+4 cycles of first assertion. The +4 covers other promoted sources of lower index on the same lane.
- Counter saturation: it stays at STARVE_LIMIT until grant. It must not wrap.
- Simultaneous flush_i and valid inputs: no grant; outputs are invalid in the next cycle.
- Simultaneous rst_n assertion and grant: the transfer is discarded; the source sees ready=0 immediately.

## Test plan
- Reset: drive rst_n=0 mid-cycle with all sources valid. Required: cdb_o[0].valid and cdb_o[1].valid drop to 0 immediately, and src_ready_o=4'b0000.
- Bank-split dual grant:
  - stimulus: ALU0 wid=6 and LSU wid=9, both valid in cycle 0;
  - required: src_ready_o=4'b0101; in cycle 1, cdb_o[0].wid=6 and cdb_o[1].wid=9, both valid.
- Bank conflict:
  - stimulus: ALU0 wid=4, ALU1 wid=8 and MDU wid=2, all held valid;
  - required: cycle 0 grants ALU0 on lane 0; cycle 1 grants ALU1 once ALU0 drops; MDU waits; lane 1 stays invalid.
- Starvation, STARVE_LIMIT=3:
  - stimulus: ALU0 presents a new bank-0 result every cycle, while MDU wid=0 is held valid;
  - required: MDU is granted in cycle 3; in that cycle src_ready_o[0]=0; MDU data appears on cdb_o[0] in cycle 4.
- Flush mid-stream:
  - stimulus: grants in cycle 0, then flush_i=1 in cycle 1 with sources still valid;
  - required: cycle 1 src_ready_o=0 while cdb_o shows the cycle-0 winners; cycle 2 both valids=0; starve counters read 0 after flush.
- Wid pass-through:
  - stimulus: LSU sends excp≠0, uncached=1, target_addr=32'h1000_0004;
  - required: the next cycle's lane output matches field-for-field, with valid=1.
